// File: rtl/rv_pkg.sv
// Shared definitions for the rv32im_zbb pipeline: ALU opcodes, forwarding selects and the
// forwarding-source selection rule shared by the hazard logic.
package rv_pkg;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_MINU  = 5'b00100;
  localparam logic [4:0] OP_MAXU  = 5'b00101;
  localparam logic [4:0] OP_SEXTH = 5'b00110;
  localparam logic [4:0] OP_SEXTB = 5'b00111;
  localparam logic [4:0] OP_MAX   = 5'b01000;
  localparam logic [4:0] OP_MIN   = 5'b01001;
  localparam logic [4:0] OP_ZEXTH = 5'b01010;
  localparam logic [4:0] OP_ORCB  = 5'b01110;
  localparam logic [4:0] OP_REV8  = 5'b01111;
  localparam logic [4:0] OP_CPOP  = 5'b10000;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  // Youngest producer wins; x0 is hardwired zero and never forwards.
  function automatic logic [1:0] fwd_select(logic use_rs, logic [4:0] rs,
                                            logic ex_we, logic [4:0] ex_rd,
                                            logic mw_we, logic [4:0] mw_rd);
    if (!use_rs) return FWD_RF;
    if (ex_we && (ex_rd != 5'd0) && (ex_rd == rs)) return FWD_EX_MEM;
    if (mw_we && (mw_rd != 5'd0) && (mw_rd == rs)) return FWD_MEM_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use hazard detection and next-cycle forwarding select generation.
module hazard_fwd_unit
  import rv_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_reg_write_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_reg_write_i,
  input  logic [4:0] ex_mem_rd_i,
  input  logic       flush_i,
  output logic       hz_o,
  output logic [1:0] mux1_sel_o,
  output logic [1:0] mux3_sel_o
);

  logic ex_load_live;
  logic rs_match;
  logic ex_we;

  assign ex_load_live = ex_valid_i & ex_mem_read_i & ex_reg_write_i & (ex_rd_i != 5'd0);
  assign rs_match     = (id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                        (id_use_rs2_i & (id_rs2_i == ex_rd_i));
  // A flush kills the consumer anyway, so stalling for it would only waste a cycle.
  assign hz_o         = id_valid_i & ex_load_live & rs_match & ~flush_i;
  assign ex_we        = ex_valid_i & ex_reg_write_i;

  always_comb begin
    mux3_sel_o = FWD_RF;
    mux1_sel_o = FWD_RF;
    mux3_sel_o = fwd_select(id_use_rs1_i, id_rs1_i, ex_we, ex_rd_i,
                            ex_mem_reg_write_i, ex_mem_rd_i);
    mux1_sel_o = fwd_select(id_use_rs2_i, id_rs2_i, ex_we, ex_rd_i,
                            ex_mem_reg_write_i, ex_mem_rd_i);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands, registers forwarding selects, inserts
// bubbles on load-use hazards and branch flushes, and freezes on a pipeline hold.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_instr_word_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [OPW-1:0]  id_alu_op_i,
  input  logic            id_use_rs1_i,
  input  logic            id_use_rs2_i,
  input  logic            id_use_imm_i,
  input  logic            id_reg_write_i,
  input  logic            id_mem_read_i,
  input  logic [4:0]      ex_mem_rd_i,
  input  logic            ex_mem_reg_write_i,
  input  logic            flush_i,
  input  logic            hold_i,
  output logic [XLEN-1:0] ex_instr_word_o,
  output logic [XLEN-1:0] ex_rs1_o,
  output logic [XLEN-1:0] ex_rs2_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [OPW-1:0]  ex_alu_op_o,
  output logic [1:0]      ex_mux1_sel_o,
  output logic            ex_mux2_sel_o,
  output logic [1:0]      ex_mux3_sel_o,
  output logic [4:0]      ex_rd_o,
  output logic            ex_reg_write_o,
  output logic            ex_mem_read_o,
  output logic            ex_valid_o,
  output logic            stall_o,
  output logic [31:0]     stall_cnt_o
);

  logic       hz;
  logic [1:0] mux1_sel_d;
  logic [1:0] mux3_sel_d;

  hazard_fwd_unit u_hazard_fwd_unit (
    .id_valid_i         (id_valid_i),
    .id_rs1_i           (id_instr_word_i[19:15]),
    .id_rs2_i           (id_instr_word_i[24:20]),
    .id_use_rs1_i       (id_use_rs1_i),
    .id_use_rs2_i       (id_use_rs2_i),
    .ex_valid_i         (ex_valid_o),
    .ex_reg_write_i     (ex_reg_write_o),
    .ex_mem_read_i      (ex_mem_read_o),
    .ex_rd_i            (ex_rd_o),
    .ex_mem_reg_write_i (ex_mem_reg_write_i),
    .ex_mem_rd_i        (ex_mem_rd_i),
    .flush_i            (flush_i),
    .hz_o               (hz),
    .mux1_sel_o         (mux1_sel_d),
    .mux3_sel_o         (mux3_sel_d)
  );

  assign stall_o = hz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_instr_word_o <= '0;
      ex_rs1_o        <= '0;
      ex_rs2_o        <= '0;
      ex_imm_o        <= '0;
      ex_alu_op_o     <= '0;
      ex_mux1_sel_o   <= FWD_RF;
      ex_mux2_sel_o   <= 1'b0;
      ex_mux3_sel_o   <= FWD_RF;
      ex_rd_o         <= 5'd0;
      ex_reg_write_o  <= 1'b0;
      ex_mem_read_o   <= 1'b0;
      ex_valid_o      <= 1'b0;
      stall_cnt_o     <= 32'd0;
    end else if (!hold_i) begin
      // Data fields load unconditionally; a bubble is defined by its control bits alone.
      ex_instr_word_o <= id_instr_word_i;
      ex_rs1_o        <= id_rs1_data_i;
      ex_rs2_o        <= id_rs2_data_i;
      ex_imm_o        <= id_imm_i;
      ex_mux1_sel_o   <= mux1_sel_d;
      ex_mux2_sel_o   <= id_use_imm_i;
      ex_mux3_sel_o   <= mux3_sel_d;
      ex_rd_o         <= id_instr_word_i[11:7];
      if (flush_i || hz) begin
        ex_valid_o     <= 1'b0;
        ex_reg_write_o <= 1'b0;
        ex_mem_read_o  <= 1'b0;
        ex_alu_op_o    <= '0;
      end else begin
        ex_valid_o     <= id_valid_i;
        ex_reg_write_o <= id_reg_write_i & id_valid_i;
        ex_mem_read_o  <= id_mem_read_i & id_valid_i;
        ex_alu_op_o    <= id_alu_op_i;
      end
      if (hz) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the rv32im_zbb core; sits directly upstream of execute_phase and drives all of its inputs except ex_mem_i and mem_wb_i.
- Latches decoded operands and opcode, and precomputes registered forwarding selects (mux1/mux2/mux3).
- Detects load-use hazards, stalls IF/ID and inserts bubbles.
- Handles branch flush and a global pipeline hold.

Parameters:
- XLEN, 32, data/instruction width
- OPW, 5, ALU opcode width (instr_i of execute stage)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid_i  in  1  decode holds a valid instruction
- id_instr_word_i  in  XLEN  raw instruction; rs1=[19:15], rs2=[24:20], rd=[11:7]
- id_rs1_data_i  in  XLEN  register file read port 1
- id_rs2_data_i  in  XLEN  register file read port 2
- id_imm_i  in  XLEN  sign-extended immediate
- id_alu_op_i  in  OPW  ALU opcode
- id_use_rs1_i  in  1  instruction reads rs1
- id_use_rs2_i  in  1  instruction reads rs2
- id_use_imm_i  in  1  operand2 comes from the immediate
- id_reg_write_i  in  1  instruction writes rd
- id_mem_read_i  in  1  instruction is a load
- ex_mem_rd_i  in  5  rd held in the EX/MEM register
- ex_mem_reg_write_i  in  1  EX/MEM writes rd
- flush_i  in  1  branch taken; kill the instruction in ID
- hold_i  in  1  memory wait; freeze this stage
- ex_instr_word_o  out  XLEN  to instr_word_i
- ex_rs1_o, ex_rs2_o, ex_imm_o  out  XLEN each  to rs1_i / rs2_i / imm_i
- ex_alu_op_o  out  OPW  to instr_i
- ex_mux1_sel_o  out  2  to mux1_sel_i
- ex_mux2_sel_o  out  1  to mux2_sel_i
- ex_mux3_sel_o  out  2  to mux3_sel_i
- ex_rd_o  out  5  destination register, to EX/MEM
- ex_reg_write_o  out  1  destination write enable, to EX/MEM
- ex_mem_read_o  out  1  load flag, to EX/MEM
- ex_valid_o  out  1  EX stage holds a valid instruction
- stall_o  out  1  combinational; freeze PC and IF/ID
- stall_cnt_o  out  32  number of load-use bubbles inserted

Behaviour:
- Reset: when rst_n=0 at the clock edge, every registered output is cleared to 0. A zero opcode (00000) makes execute produce 0. Reset wins over every other input.
- Latency: 1 cycle from ID to the EX outputs.
- Update priority each edge: reset > hold_i > flush_i > load-use > normal.
- hold_i=1: all registers keep their value, stall_cnt_o does not count, and flush_i is ignored. The flush source keeps flush_i asserted until hold_i drops. stall_o still reflects the load-use compare.
- Load-use hazard, combinational:
  - hz = id_valid_i & ex_valid_o & ex_mem_read_o & ex_reg_write_o & (ex_rd_o != 0)
  - and ((id_use_rs1_i & rs1 == ex_rd_o) | (id_use_rs2_i & rs2 == ex_rd_o))
  - and !flush_i.
  - stall_o = hz.
- Bubble (load-use or flush):
  - ex_valid_o, ex_reg_write_o and ex_mem_read_o are set to 0, and ex_alu_op_o to 0.
  - Data fields may load any value.
  - stall_cnt_o increments by 1 on a load-use bubble only, not on flush. It wraps at 2^32-1 to 0.
- Normal load: all ID fields are captured. ex_valid_o = id_valid_i. ex_reg_write_o and ex_mem_read_o are gated by id_valid_i.
- Forwarding selects, registered with the instruction for use in the following EX cycle. For operand1 (mux3) using rs1, and operand2 (mux1) using rs2:
  - 10 (EX/MEM): the current EX-stage instruction has ex_valid_o & ex_reg_write_o & (ex_rd_o != 0) & ex_rd_o == rsX. That instruction is in EX/MEM next cycle.
  - 01 (MEM/WB): otherwise, ex_mem_reg_write_i & (ex_mem_rd_i != 0) & ex_mem_rd_i == rsX.
  - 00 (register file): otherwise.
  - 11 is never generated.
  - A select is forced to 00 when its use_rsX flag is 0.
- ex_mux2_sel_o = id_use_imm_i.
- Register x0 never forwards.
- Register file is write-through, so a same-cycle writeback reaches the read data directly.
- After a load-use stall the load sits in EX/MEM while the bubble sits in EX, so the consumer receives select 01 automatically.
- flush_i together with hz: flush wins and stall_o=0.

Decomposition:
- Shared package rv_pkg:
  - ALU opcode constants: OP_NOP=00000, OP_MINU=00100, OP_MAXU=00101, OP_SEXTH=00110, OP_SEXTB=00111, OP_MAX=01000, OP_MIN=01001, OP_ZEXTH=01010, OP_ORCB=01110, OP_REV8=01111, OP_CPOP=10000.
  - Forwarding constants: FWD_RF=00, FWD_MEM_WB=01, FWD_EX_MEM=10.
- One combinational sub-module, hazard_fwd_unit: computes hz and the next mux1/mux3 selects.
- id_ex_stage holds the registers and the stall counter.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all inputs at random values -> all outputs 0, stall_o=0.
- EX forwarding: `add x5` in EX (reg_write=1), then ID `minu x6,x5,x7` -> ex_mux3_sel_o=10, ex_mux1_sel_o=00, ex_alu_op_o=00100 one cycle later.
- Load-use: `lw x5` in EX, ID uses rs2=x5 -> stall_o=1, then bubble (ex_valid_o=0), stall_cnt_o 0->1. Next cycle stall_o=0 and the consumer is captured with ex_mux1_sel_o=01.
- Flush priority: flush_i=1 while hz=1 -> stall_o=0, bubble captured, stall_cnt_o unchanged.
- Hold: hold_i=1 for 3 cycles with changing ID inputs -> outputs frozen at prior values. When hold_i drops, the flush_i held high produces a bubble.
- x0 and immediate: ID rs1=x0 with EX rd=x0 and reg_write=1 -> mux3_sel=00. With id_use_imm_i=1 and imm=0xFFFFF800 -> ex_mux2_sel_o=1, ex_imm_o=0xFFFFF800.
